// File: rtl/au_arbiter.sv
// rtl/au_arbiter.sv - round-robin arbiter sharing one arithmetic unit among N requesters
// Optional DIV watchdog: define AU_ARB_TIMEOUT_EN.
module au_arbiter #(
  parameter int W   = 24,
  parameter int N   = 4,
  parameter int TMO = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [2*N-1:0] req_op,
  input  logic [N*W-1:0] req_r,
  input  logic [N*W-1:0] req_s,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           au_start,
  output logic [W-1:0]   au_R,
  output logic [W-1:0]   au_S,
  output logic [W-1:0]   au_I,
  output logic [1:0]     au_ctl_d,
  input  logic [W-1:0]   au_result_comb,
  input  logic           au_result_comb_valid,
  input  logic [W-1:0]   au_result,
  input  logic           au_done,
  output logic           busy
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] ptr, g_q, win, cand;
  logic          found;
  logic [1:0]    sel_op, op_q;
  logic [W-1:0]  sel_r, sel_s, r_q, s_q, data_q;
  logic          err_q;
  logic          wd_expire;

  // Scan from ptr upward, wrapping, and take the first pending requester.
  always_comb begin
    win    = '0;
    cand   = '0;
    found  = 1'b0;
    sel_op = '0;
    sel_r  = '0;
    sel_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_r  = req_r[W*i +: W];
        sel_s  = req_s[W*i +: W];
      end
    end
  end

`ifdef AU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + CW'(1);
  end

  assign wd_expire = (state == WAIT) && (wd_cnt == CW'(TMO - 1));
`else
  // Without the watchdog TMO has no effect; this reduces to constant 0.
  assign wd_expire = (TMO < 0);
`endif

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    au_start  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        au_start  = 1'b1;
        state_nxt = (op_q == OP_DIV) ? WAIT : RESP;
      end
      WAIT: begin
        if (au_done || wd_expire) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      g_q    <= '0;
      op_q   <= '0;
      r_q    <= '0;
      s_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            g_q  <= win;
            op_q <= sel_op;
            r_q  <= sel_r;
            s_q  <= sel_s;
            ptr  <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
          end
        end
        EXEC: begin
          if (op_q != OP_DIV) begin
            data_q <= au_result_comb;
            err_q  <= ~au_result_comb_valid;
          end
        end
        WAIT: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (au_done) begin
            data_q <= au_result;
            err_q  <= 1'b0;
          end else if (wd_expire) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign au_R     = (state == EXEC || state == WAIT) ? r_q : '0;
  assign au_S     = (state == EXEC || state == WAIT) ? s_q : '0;
  assign au_ctl_d = (state == EXEC || state == WAIT) ? op_q : '0;
  assign au_I     = '0;
  assign rsp_data = (state == RESP) ? data_q : '0;
  assign rsp_err  = (state == RESP) && err_q;

endmodule
